mem_arbiter: RTL and testbench

- Sits directly downstream of the data cache and the instruction cache in the single-core MIPS memory hierarchy.
- Arbitrates both cache-side request ports onto the one RAM port.
- Returns wait/load to each cache.
- Dcache has fixed priority; a starvation counter guarantees icache forward progress.

---
 rtl/cpu_types_pkg.sv | 22 ++
 rtl/mem_arbiter_starve_counter.sv | 36 +++
 rtl/mem_arbiter.sv | 136 +++++++++++++
 tb/tb_mem_arbiter.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_types_pkg.sv
// Shared memory-hierarchy types: RAM handshake state, word type and arbiter state.
// Also used by the cache-control bench monitors.
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DGRANT = 2'd1,
        IGRANT = 2'd2
    } arb_state_t;

    localparam int STARVE_W = 4;

endpackage

// File: rtl/mem_arbiter_starve_counter.sv
// Saturating count of dcache wins taken while an icache request waits.
// sat_o is a registered compare; clr_i takes precedence over inc_i.
module starve_counter
    import cpu_types_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input  logic CLK,
    input  logic nRST,
    input  logic inc_i,
    input  logic clr_i,
    output logic sat_o
);

    localparam logic [STARVE_W-1:0] LIMIT = STARVE_LIMIT[STARVE_W-1:0];

    logic [STARVE_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i)
            cnt_d = '0;
        else if (inc_i && (cnt_q != LIMIT))
            cnt_d = cnt_q + 4'd1;
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

    assign sat_o = (cnt_q == LIMIT);

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates dcache (fixed priority) and icache onto one RAM port; min 2-cycle latency.
// Optional access counters under MEM_ARB_STATS_EN. Requesters stall on wait=1 until ACCESS.
module mem_arbiter
    import cpu_types_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        iREN,
    input  logic [31:0] iaddr,
    output logic        iwait,
    output logic [31:0] iload,
    input  logic        dREN,
    input  logic        dWEN,
    input  logic [31:0] daddr,
    input  logic [31:0] dstore,
    output logic        dwait,
    output logic [31:0] dload,
    output logic        ramREN,
    output logic        ramWEN,
    output logic [31:0] ramaddr,
    output logic [31:0] ramstore,
    input  logic [31:0] ramload,
    input  logic [1:0]  ramstate
`ifdef MEM_ARB_STATS_EN
    ,
    output logic [31:0] dcount,
    output logic [31:0] icount
`endif
);

    arb_state_t state_q, state_d;
    logic       dreq, acc, starve_inc, starve_clr, starve_sat;

    assign dreq = dREN | dWEN;
    assign acc  = (ramstate == ACCESS);

    starve_counter #(.STARVE_LIMIT(STARVE_LIMIT)) u_starve (
        .CLK   (CLK),
        .nRST  (nRST),
        .inc_i (starve_inc),
        .clr_i (starve_clr),
        .sat_o (starve_sat)
    );

    always_comb begin
        state_d    = state_q;
        starve_inc = 1'b0;
        starve_clr = 1'b0;
        case (state_q)
            IDLE: begin
                if (dreq && !(iREN && starve_sat))
                    state_d = DGRANT;
                else if (iREN)
                    state_d = IGRANT;
            end
            DGRANT: begin
                if (!dreq) begin
                    state_d = IDLE;
                end else if (acc) begin
                    state_d    = IDLE;
                    starve_inc = iREN;
                    starve_clr = !iREN;
                end
            end
            IGRANT: begin
                if (!iREN) begin
                    state_d = IDLE;
                end else if (acc) begin
                    state_d    = IDLE;
                    starve_clr = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    // Strobes follow the live request so a withdrawn request never reaches RAM.
    always_comb begin
        ramREN   = 1'b0;
        ramWEN   = 1'b0;
        ramaddr  = '0;
        ramstore = '0;
        iwait    = 1'b1;
        dwait    = 1'b1;
        case (state_q)
            DGRANT: begin
                ramaddr = daddr;
                if (dWEN) begin
                    ramWEN   = 1'b1;
                    ramstore = dstore;
                end else begin
                    ramREN = dREN;
                end
                dwait = !(dreq && acc);
            end
            IGRANT: begin
                ramREN  = iREN;
                ramaddr = iaddr;
                iwait   = !(iREN && acc);
            end
            default: ;
        endcase
    end

    assign iload = ramload;
    assign dload = ramload;

`ifdef MEM_ARB_STATS_EN
    logic [31:0] dcount_q, icount_q;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            dcount_q <= '0;
            icount_q <= '0;
        end else begin
            if (state_q == DGRANT && dreq && acc)
                dcount_q <= dcount_q + 32'd1;
            if (state_q == IGRANT && iREN && acc)
                icount_q <= icount_q + 32'd1;
        end
    end

    assign dcount = dcount_q;
    assign icount = icount_q;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed vector table, starvation/reset sequences
// and randomized traffic against a transaction-level owner model.
module tb_mem_arbiter;

    localparam int LIMIT = 4;

    logic        CLK = 1'b0;
    logic        nRST;
    logic        iREN, dREN, dWEN;
    logic [31:0] iaddr, daddr, dstore, ramload;
    logic [1:0]  ramstate;
    logic        iwait, dwait, ramREN, ramWEN;
    logic [31:0] iload, dload, ramaddr, ramstore;
`ifdef MEM_ARB_STATS_EN
    logic [31:0] dcount, icount;
`endif

    mem_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
        .CLK(CLK), .nRST(nRST),
        .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
        .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
        .dwait(dwait), .dload(dload),
        .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
        .ramload(ramload), .ramstate(ramstate)
`ifdef MEM_ARB_STATS_EN
        , .dcount(dcount), .icount(icount)
`endif
    );

    always #5 CLK = ~CLK;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic do_reset();
        nRST = 1'b0;
        iREN = 0; dREN = 0; dWEN = 0;
        iaddr = 0; daddr = 0; dstore = 0; ramload = 0; ramstate = 2'd0;
        repeat (2) @(negedge CLK);
        nRST = 1'b1;
    endtask

    typedef struct {
        logic        iren, dren, dwen;
        logic [31:0] da, ds;
        logic [1:0]  rs;
        logic        e_ren, e_wen, e_iw, e_dw;
        logic [31:0] e_addr, e_store;
    } vec_t;

    function automatic vec_t mk(input logic dr, input logic dw, input logic [31:0] da,
                                input logic [31:0] ds, input logic [1:0] rs,
                                input logic er, input logic ew, input logic edw,
                                input logic [31:0] ea, input logic [31:0] es);
        vec_t v;
        v.iren = 1'b0; v.dren = dr; v.dwen = dw; v.da = da; v.ds = ds; v.rs = rs;
        v.e_ren = er; v.e_wen = ew; v.e_iw = 1'b1; v.e_dw = edw;
        v.e_addr = ea; v.e_store = es;
        return v;
    endfunction

    // Transaction-level reference: who owns the RAM port and how long icache has waited.
    int m_owner;   // 0 none, 1 dcache, 2 icache
    int m_starve;
    int m_dcnt, m_icnt;

    task automatic model_check();
        logic        e_ren, e_wen, e_iw, e_dw, acc, dreq;
        logic [31:0] e_addr, e_store;
        acc  = (ramstate == 2'd2);
        dreq = dREN | dWEN;
        e_ren = 0; e_wen = 0; e_iw = 1; e_dw = 1; e_addr = 0; e_store = 0;
        if (m_owner == 1) begin
            e_addr = daddr;
            if (dWEN) begin e_wen = 1; e_store = dstore; end
            else e_ren = dREN;
            e_dw = !(dreq && acc);
        end else if (m_owner == 2) begin
            e_addr = iaddr;
            e_ren  = iREN;
            e_iw   = !(iREN && acc);
        end
        chk("rnd_ramREN", {31'b0, ramREN}, {31'b0, e_ren});
        chk("rnd_ramWEN", {31'b0, ramWEN}, {31'b0, e_wen});
        chk("rnd_ramaddr", ramaddr, e_addr);
        chk("rnd_ramstore", ramstore, e_store);
        chk("rnd_iwait", {31'b0, iwait}, {31'b0, e_iw});
        chk("rnd_dwait", {31'b0, dwait}, {31'b0, e_dw});
        chk("rnd_onehot", {31'b0, ~iwait & ~dwait}, 32'd0);
        chk("rnd_iload", iload, ramload);
        chk("rnd_dload", dload, ramload);
    endtask

    task automatic model_step();
        logic acc, dreq;
        acc  = (ramstate == 2'd2);
        dreq = dREN | dWEN;
        case (m_owner)
            0: begin
                if (dreq && !(iREN && m_starve == LIMIT)) m_owner = 1;
                else if (iREN) m_owner = 2;
            end
            1: begin
                if (!dreq) m_owner = 0;
                else if (acc) begin
                    m_owner = 0;
                    m_dcnt++;
                    m_starve = iREN ? ((m_starve < LIMIT) ? m_starve + 1 : LIMIT) : 0;
                end
            end
            default: begin
                if (!iREN) m_owner = 0;
                else if (acc) begin
                    m_owner = 0;
                    m_icnt++;
                    m_starve = 0;
                end
            end
        endcase
    endtask

    vec_t tbl[15];
    byte  grants[10];
    string exp_order = "DDDDIDDDDI";

    initial begin
        tbl[0]  = mk(1, 0, 32'h40,   0,     2'd0, 0, 0, 1, 0,       0);
        tbl[1]  = mk(1, 0, 32'h40,   0,     2'd1, 1, 0, 1, 32'h40,  0);
        tbl[2]  = mk(1, 0, 32'h40,   0,     2'd2, 1, 0, 0, 32'h40,  0);
        tbl[3]  = mk(1, 1, 32'h3100, 32'h12, 2'd0, 0, 0, 1, 0,       0);
        tbl[4]  = mk(1, 1, 32'h3100, 32'h12, 2'd2, 0, 1, 0, 32'h3100, 32'h12);
        tbl[5]  = mk(1, 0, 32'h80,   0,     2'd1, 0, 0, 1, 0,       0);
        tbl[6]  = mk(1, 0, 32'h80,   0,     2'd1, 1, 0, 1, 32'h80,  0);
        tbl[7]  = mk(0, 0, 32'h80,   0,     2'd1, 0, 0, 1, 32'h80,  0);
        tbl[8]  = mk(0, 0, 32'h80,   0,     2'd0, 0, 0, 1, 0,       0);
        tbl[9]  = mk(1, 0, 32'h90,   0,     2'd3, 0, 0, 1, 0,       0);
        tbl[10] = mk(1, 0, 32'h90,   0,     2'd3, 1, 0, 1, 32'h90,  0);
        tbl[11] = mk(1, 0, 32'h90,   0,     2'd3, 1, 0, 1, 32'h90,  0);
        tbl[12] = mk(1, 0, 32'h90,   0,     2'd3, 1, 0, 1, 32'h90,  0);
        tbl[13] = mk(1, 0, 32'h90,   0,     2'd2, 1, 0, 0, 32'h90,  0);
        tbl[14] = mk(0, 0, 32'h90,   0,     2'd0, 0, 0, 1, 0,       0);

        // Reset values while nRST is low.
        nRST = 1'b0;
        iREN = 0; dREN = 0; dWEN = 0;
        iaddr = 0; daddr = 0; dstore = 0; ramload = 0; ramstate = 2'd0;
        #3;
        chk("rst_iwait", {31'b0, iwait}, 32'd1);
        chk("rst_dwait", {31'b0, dwait}, 32'd1);
        chk("rst_ramREN", {31'b0, ramREN}, 32'd0);
        chk("rst_ramWEN", {31'b0, ramWEN}, 32'd0);
        chk("rst_ramaddr", ramaddr, 32'd0);
        chk("rst_ramstore", ramstore, 32'd0);
        @(negedge CLK);
        nRST = 1'b1;

        // Directed vectors: read with BUSY, write-wins, withdrawal, ERROR stall.
        ramload = 32'hCAFEF00D;
        for (int i = 0; i < 15; i++) begin
            @(negedge CLK);
            iREN = tbl[i].iren; dREN = tbl[i].dren; dWEN = tbl[i].dwen;
            daddr = tbl[i].da; dstore = tbl[i].ds; ramstate = tbl[i].rs;
            #1;
            chk($sformatf("vec%0d_ramREN", i), {31'b0, ramREN}, {31'b0, tbl[i].e_ren});
            chk($sformatf("vec%0d_ramWEN", i), {31'b0, ramWEN}, {31'b0, tbl[i].e_wen});
            chk($sformatf("vec%0d_ramaddr", i), ramaddr, tbl[i].e_addr);
            chk($sformatf("vec%0d_ramstore", i), ramstore, tbl[i].e_store);
            chk($sformatf("vec%0d_iwait", i), {31'b0, iwait}, {31'b0, tbl[i].e_iw});
            chk($sformatf("vec%0d_dwait", i), {31'b0, dwait}, {31'b0, tbl[i].e_dw});
            if (!tbl[i].e_dw)
                chk($sformatf("vec%0d_dload", i), dload, 32'hCAFEF00D);
        end
`ifdef MEM_ARB_STATS_EN
        chk("vec_dcount", dcount, 32'd3);
        chk("vec_icount", icount, 32'd0);
`endif

        // Starvation: both caches request continuously, RAM always ready.
        @(negedge CLK);
        iREN = 1; dREN = 1; dWEN = 0; iaddr = 32'h1000; daddr = 32'h2000; ramstate = 2'd2;
        begin
            int ng = 0;
            for (int c = 0; c < 40 && ng < 10; c++) begin
                #1;
                if (!dwait) begin grants[ng] = "D"; ng++; end
                else if (!iwait) begin grants[ng] = "I"; ng++; end
                @(negedge CLK);
            end
            chk("starve_grant_count", ng, 10);
            for (int g = 0; g < ng; g++)
                chk($sformatf("starve_grant%0d", g), {24'b0, grants[g]}, {24'b0, exp_order[g]});
        end
        iREN = 0; dREN = 0; ramstate = 2'd0;

        // Async reset during IGRANT.
        @(negedge CLK);
        iREN = 1; iaddr = 32'h500; ramstate = 2'd1;
        @(negedge CLK);
        #1;
        chk("irst_pre_ramREN", {31'b0, ramREN}, 32'd1);
        chk("irst_pre_ramaddr", ramaddr, 32'h500);
        #1;
        nRST = 1'b0;
        #1;
        chk("irst_ramREN", {31'b0, ramREN}, 32'd0);
        chk("irst_iwait", {31'b0, iwait}, 32'd1);
        chk("irst_ramaddr", ramaddr, 32'd0);
        @(negedge CLK);
        nRST = 1'b1;
        #1;
        chk("irst_idle_ramREN", {31'b0, ramREN}, 32'd0);
        @(negedge CLK);
        #1;
        chk("irst_regrant_ramREN", {31'b0, ramREN}, 32'd1);
        chk("irst_regrant_ramaddr", ramaddr, 32'h500);

        // Randomized traffic against the owner model.
        do_reset();
        m_owner = 0; m_starve = 0; m_dcnt = 0; m_icnt = 0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge CLK);
            if ($urandom_range(0, 3) == 0) iREN = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 3) == 0) dREN = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 5) == 0) dWEN = 1'($urandom_range(0, 1));
            iaddr = $urandom; daddr = $urandom; dstore = $urandom; ramload = $urandom;
            begin
                int r = $urandom_range(0, 7);
                ramstate = (r >= 4) ? 2'd2 : 2'(r);
            end
            #1;
            model_check();
            @(posedge CLK);
            model_step();
        end
        @(negedge CLK);
`ifdef MEM_ARB_STATS_EN
        chk("rnd_dcount", dcount, m_dcnt);
        chk("rnd_icount", icount, m_icnt);
`endif
        chk("rnd_any_dack", {31'b0, m_dcnt > 0}, 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
